// File: rtl/fir_driver.sv
// Initiator for a 16-tap fir core: buffers a sample window, replays the wind/load/fire
// push sequence, and returns the captured fir result on a valid/ready port.
module fir_driver #(
    parameter int unsigned TAPS     = 16,
    parameter int unsigned DW       = 16,
    parameter int unsigned FIRE_LEN = 6,
    parameter int unsigned TIMEOUT  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_wr,
    input  logic [3:0]    w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          fir_wind,
    output logic          fir_load,
    output logic          fir_in_valid,
    output logic [DW-1:0] fir_data,
    input  logic          fir_out_valid,
    input  logic [DW-1:0] fir_out,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    input  logic          res_ready,
    output logic          busy,
    output logic          err
);

    localparam int unsigned CW = $clog2(TAPS);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StCollect,
        StWind,
        StLoad,
        StGap,
        StFire,
        StWait,
        StHold
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [DW-1:0] window_q [TAPS];
    logic [DW-1:0] weight_q [TAPS];

    logic          s_ready_q, s_ready_d;
    logic          busy_q, busy_d;
    logic          fir_wind_q, fir_wind_d;
    logic          fir_load_q, fir_load_d;
    logic          fir_in_valid_q, fir_in_valid_d;
    logic [DW-1:0] fir_data_q, fir_data_d;
    logic          res_valid_q, res_valid_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          err_q, err_d;

    logic          accept;
    logic          w_en;

    assign accept = s_valid && s_ready_q;
    assign w_en   = w_wr && (state_q == StCollect);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        err_d       = err_q;
        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TAPS - 1)) begin
                        state_d = StWind;
                        cnt_d   = '0;
                    end
                end
            end
            StWind: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(TAPS - 1)) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(TAPS - 1)) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                state_d = StFire;
                tmo_d   = '0;
            end
            StFire, StWait: begin
                // One counter both times the in_valid pulse and bounds the wait for a result.
                tmo_d = tmo_q + TW'(1);
                if (fir_out_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = fir_out;
                    state_d     = StHold;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StCollect;
                    cnt_d   = '0;
                end else if (state_q == StFire && tmo_q == TW'(FIRE_LEN - 1)) begin
                    state_d = StWait;
                end
            end
            StHold: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StCollect;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = StCollect;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q after each edge.
    always_comb begin
        s_ready_d      = 1'b0;
        busy_d         = 1'b1;
        fir_wind_d     = 1'b0;
        fir_load_d     = 1'b0;
        fir_in_valid_d = 1'b0;
        fir_data_d     = '0;
        unique case (state_d)
            StCollect: begin
                s_ready_d = 1'b1;
                busy_d    = 1'b0;
            end
            StWind: begin
                fir_wind_d = 1'b1;
                fir_data_d = window_q[cnt_d];
            end
            StLoad: begin
                fir_load_d = 1'b1;
                fir_data_d = weight_q[cnt_d];
            end
            StGap: begin
                fir_data_d = fir_data_q;
            end
            StFire: begin
                fir_in_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StCollect;
            cnt_q          <= '0;
            tmo_q          <= '0;
            s_ready_q      <= 1'b0;
            busy_q         <= 1'b0;
            fir_wind_q     <= 1'b0;
            fir_load_q     <= 1'b0;
            fir_in_valid_q <= 1'b0;
            fir_data_q     <= '0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            s_ready_q      <= s_ready_d;
            busy_q         <= busy_d;
            fir_wind_q     <= fir_wind_d;
            fir_load_q     <= fir_load_d;
            fir_in_valid_q <= fir_in_valid_d;
            fir_data_q     <= fir_data_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            err_q          <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                window_q[i] <= '0;
                weight_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                window_q[cnt_q] <= s_data;
            end
            if (w_en) begin
                weight_q[w_addr] <= w_data;
            end
        end
    end

    assign s_ready      = s_ready_q;
    assign busy         = busy_q;
    assign fir_wind     = fir_wind_q;
    assign fir_load     = fir_load_q;
    assign fir_in_valid = fir_in_valid_q;
    assign fir_data     = fir_data_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fir_driver.sv
// Directed bench for fir_driver; a small in-line fir model answers each fire with the dot
// product of the pushed window and weights, presented so the driver captures it 8 cycles on.
module tb_fir_driver;

    localparam int TIMEOUT = 32;

    logic        clk;
    logic        rst;
    logic        w_wr;
    logic [3:0]  w_addr;
    logic [15:0] w_data;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        fir_wind;
    logic        fir_load;
    logic        fir_in_valid;
    logic [15:0] fir_data;
    logic        fir_out_valid;
    logic [15:0] fir_out;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_ready;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [15:0] smp    [16];
    logic [15:0] wts    [16];
    logic [15:0] exp_wt [16];

    fir_driver dut (
        .clk          (clk),
        .rst          (rst),
        .w_wr         (w_wr),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .fir_wind     (fir_wind),
        .fir_load     (fir_load),
        .fir_in_valid (fir_in_valid),
        .fir_data     (fir_data),
        .fir_out_valid(fir_out_valid),
        .fir_out      (fir_out),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_ready    (res_ready),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Streams smp[] into the driver, optionally writing wts[] in the same cycles.
    task automatic send(input bit gap, input bit with_w);
        int acc;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            if (gap) begin
                s_valid = 1'b0;
                w_wr    = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_data  = smp[i];
            if (with_w) begin
                w_wr   = 1'b1;
                w_addr = 4'(i);
                w_data = wts[i];
            end
            if (s_ready) acc++;
            tick();
        end
        s_valid = 1'b0;
        w_wr    = 1'b0;
        chk("accept_count", 32'(acc), 32'd16);
        chk("s_ready_after_window", 32'(s_ready), 32'd0);
    endtask

    // Entered one cycle after the 16th accept; checks the full push sequence and the result.
    task automatic run_frame(input bit respond, input int hold, input logic [15:0] exp_res,
                             input bit busy_wr);
        logic [15:0] pw [16];
        logic [15:0] pl [16];
        logic [15:0] dot;
        for (int i = 0; i < 16; i++) begin
            chk("wind", 32'({fir_wind, fir_load, fir_in_valid, fir_data}),
                32'({3'b100, smp[i]}));
            if (i == 0) chk("busy_wind", 32'(busy), 32'd1);
            pw[i] = fir_data;
            if (busy_wr && i == 2) begin
                w_wr   = 1'b1;
                w_addr = 4'd3;
                w_data = 16'd99;
            end
            tick();
            w_wr = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            chk("load", 32'({fir_wind, fir_load, fir_in_valid, fir_data}),
                32'({3'b010, exp_wt[i]}));
            pl[i] = fir_data;
            tick();
        end
        chk("gap", 32'({fir_wind, fir_load, fir_in_valid, fir_data}), 32'({3'b000, exp_wt[15]}));
        tick();
        dot = '0;
        for (int i = 0; i < 16; i++) dot = dot + 16'(pw[i] * pl[i]);
        for (int c = 0; c < 8; c++) begin
            chk("fire", 32'({fir_wind, fir_load, fir_in_valid, fir_data}),
                32'({2'b00, (c < 6), 16'h0000}));
            chk("res_valid_early", 32'(res_valid), 32'd0);
            if (respond && c == 7) begin
                fir_out_valid = 1'b1;
                fir_out       = dot;
            end
            tick();
            fir_out_valid = 1'b0;
        end
        if (respond) begin
            for (int h = 0; h < hold; h++) begin
                chk("hold_valid", 32'(res_valid), 32'd1);
                chk("hold_data", 32'(res_data), 32'(exp_res));
                chk("hold_s_ready", 32'(s_ready), 32'd0);
                if (h == 5) begin
                    fir_out_valid = 1'b1;
                    fir_out       = 16'hdead;
                end
                tick();
                fir_out_valid = 1'b0;
            end
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("res_data", 32'(res_data), 32'(exp_res));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk("res_valid_cleared", 32'(res_valid), 32'd0);
            chk("collect_resumed", 32'({s_ready, busy}), 32'b10);
        end else begin
            for (int c = 8; c < TIMEOUT; c++) begin
                if (c == TIMEOUT - 1) chk("err_early", 32'(err), 32'd0);
                tick();
            end
            chk("err_timeout", 32'(err), 32'd1);
            chk("timeout_res_valid", 32'(res_valid), 32'd0);
            chk("timeout_collect", 32'({s_ready, busy}), 32'b10);
        end
    endtask

    initial begin
        rst           = 1'b1;
        w_wr          = 1'b0;
        w_addr        = '0;
        w_data        = '0;
        s_valid       = 1'b0;
        s_data        = '0;
        fir_out_valid = 1'b0;
        fir_out       = '0;
        res_ready     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            smp[i]    = 16'(i + 1);
            wts[i]    = 16'(i + 1);
            exp_wt[i] = 16'(i + 1);
        end

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("reset_outputs", 32'({s_ready, fir_wind, fir_load, fir_in_valid, res_valid, busy,
                                  err}), 32'd0);
        chk("reset_fir_data", 32'(fir_data), 32'd0);
        tick();
        tick();
        chk("reset_held_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("s_ready_after_release", 32'({s_ready, busy}), 32'b10);

        // Frame 1: weights written alongside the samples
        send(1'b0, 1'b1);
        run_frame(1'b1, 0, 16'd1496, 1'b0);

        // Frame 2: address 5 written twice, result held against backpressure
        w_wr = 1'b1; w_addr = 4'd5; w_data = 16'd77;
        tick();
        w_data = 16'd6;
        tick();
        w_wr = 1'b0;
        send(1'b0, 1'b0);
        run_frame(1'b1, 20, 16'd1496, 1'b0);

        // Frame 3: fir never answers
        send(1'b0, 1'b0);
        run_frame(1'b0, 0, 16'd0, 1'b0);

        // Frame 4: write to weight 3 while busy must be dropped
        send(1'b0, 1'b0);
        run_frame(1'b1, 0, 16'd1496, 1'b1);
        chk("err_sticky", 32'(err), 32'd1);

        // Frame 5: samples 16..1 with idle gaps
        for (int i = 0; i < 16; i++) smp[i] = 16'(16 - i);
        send(1'b1, 1'b0);
        run_frame(1'b1, 0, 16'd816, 1'b0);

        // Frame 6: reset during the 10th load cycle, then a clean frame
        for (int i = 0; i < 16; i++) smp[i] = 16'(i + 1);
        send(1'b0, 1'b0);
        for (int i = 0; i < 25; i++) tick();
        chk("load10_before_reset", 32'({fir_load, fir_data}), 32'({1'b1, 16'd10}));
        #2 rst = 1'b0;
        #1;
        chk("async_reset_fir", 32'({fir_wind, fir_load, fir_in_valid, fir_data}), 32'd0);
        chk("async_reset_busy_err", 32'({busy, err, s_ready}), 32'd0);
        #1 rst = 1'b1;
        tick();
        chk("s_ready_after_abort", 32'(s_ready), 32'd1);
        send(1'b0, 1'b1);
        run_frame(1'b1, 0, 16'd1496, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
